// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback block: opcodes, FSM states
// and the bit positions of the fields in the 16-bit instruction word.
package alu_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int INSTR_W  = 16;

  // Opcodes 0000..1101 are passed straight to the ALU as ALU_Sel
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_SHL   = 4'b0100;
  localparam logic [3:0] OP_SHR   = 4'b0101;
  localparam logic [3:0] OP_ROL   = 4'b0110;
  localparam logic [3:0] OP_ROR   = 4'b0111;
  localparam logic [3:0] OP_AND   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1011;
  localparam logic [3:0] OP_NAND  = 4'b1100;
  localparam logic [3:0] OP_XNOR  = 4'b1101;
  localparam logic [3:0] OP_ILL   = 4'b1110;
  localparam logic [3:0] OP_LOADI = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WB
  } state_t;

  // Instruction layout: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/alu_regfile.sv
// Small register file for the ALU issue block: two combinational operand
// read ports, one combinational debug read port, one synchronous write port.
module alu_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register storage: cleared on reset, one write per cycle when we is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see the contents before the current edge's write
  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the external 8-bit ALU. One instruction at a
// time: IDLE accepts, ISSUE registers operands onto the ALU inputs, WB samples
// the ALU result and updates the register file and status flags; done pulses
// in the following IDLE cycle.
// Optional feature: define ALU_ZFLAG_EN to add the zero_flag output.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              done,
  output logic              carry_flag,
  output logic              div0_flag,
  output logic              illegal,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_ZFLAG_EN
  ,
  output logic              zero_flag
`endif
);

  state_t            state_reg;
  state_t            state_next;
  logic [15:0]       instr_reg;
  logic [3:0]        op;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [7:0]        imm;
  logic              accept;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              in_wb;
  logic              is_loadi;
  logic              is_alu_op;
  logic              div_by_zero;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  assign op     = instr_reg[OP_MSB:OP_LSB];
  assign rd     = instr_reg[RD_MSB:RD_LSB];
  assign rs     = instr_reg[RS_MSB:RS_LSB];
  assign imm    = instr_reg[IMM_MSB:IMM_LSB];
  assign accept = in_valid && in_ready;

  alu_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wr_en),
    .waddr    (rd),
    .wdata    (wr_data),
    .raddr_a  (rd),
    .rdata_a  (rdata_a),
    .raddr_b  (rs),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and ready: only IDLE accepts, anything else runs to completion
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Writeback decode; the divisor check uses the registered B operand
  always_comb begin
    in_wb       = (state_reg == WB);
    is_loadi    = (op == OP_LOADI);
    is_alu_op   = (op <= OP_XNOR);
    div_by_zero = (op == OP_DIV) && (alu_b == '0);
    wr_en       = in_wb && (is_loadi || (is_alu_op && !div_by_zero));
    wr_data     = is_loadi ? imm : alu_result;
  end

  // Instruction register, loaded on the accepting handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg <= '0;
    end else if (accept) begin
      instr_reg <= in_instr;
    end
  end

  // Operand/select registers feeding the ALU, stable throughout WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (state_reg == ISSUE) begin
      alu_a   <= rdata_a;
      alu_b   <= rdata_b;
      alu_sel <= is_loadi ? 4'b0000 : op;
    end
  end

  // Retirement pulses and status flags, all updated at the end of WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done       <= 1'b0;
      illegal    <= 1'b0;
      carry_flag <= 1'b0;
      div0_flag  <= 1'b0;
    end else begin
      done    <= in_wb;
      illegal <= in_wb && (op == OP_ILL);
      if (in_wb && (op == OP_ADD)) begin
        carry_flag <= alu_carry;
      end
      if (in_wb && (op == OP_DIV)) begin
        div0_flag <= div_by_zero;
      end
    end
  end

`ifdef ALU_ZFLAG_EN
  // Zero flag tracks the value of the most recent register write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
    end else if (wr_en) begin
      zero_flag <= (wr_data == '0);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a combinational ALU stand-in, an instruction-level
// reference model checked every cycle, and directed sequences with literal
// expectations.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        done;
  logic        carry_flag;
  logic        div0_flag;
  logic        illegal;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;
`ifdef ALU_ZFLAG_EN
  logic        zero_flag;
`endif

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .done       (done),
    .carry_flag (carry_flag),
    .div0_flag  (div0_flag),
    .illegal    (illegal),
    .dbg_addr   (dbg_addr),
`ifdef ALU_ZFLAG_EN
    .zero_flag  (zero_flag),
`endif
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU semantics (stand-in for the real 8-bit ALU)
  function automatic logic [7:0] alu_fn(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (sel)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = (b == 8'd0) ? 8'd0 : a / b;
      4'd4:    r = a << 1;
      4'd5:    r = a >> 1;
      4'd6:    r = {a[6:0], a[7]};
      4'd7:    r = {a[0], a[7:1]};
      4'd8:    r = a & b;
      4'd9:    r = a | b;
      4'd10:   r = a ^ b;
      4'd11:   r = ~(a | b);
      4'd12:   r = ~(a & b);
      4'd13:   r = ~(a ^ b);
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  function automatic logic add_carry(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8];
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_sel, alu_a, alu_b);
    alu_carry  = add_carry(alu_a, alu_b);
  end

  // Reference model: architectural effect computed at accept, made visible at retire
  typedef struct {
    int             due;
    int             wbc;
    logic [3:0][7:0] regs;
    logic           carry;
    logic           div0;
    logic           zero;
    logic           ill;
    logic [7:0]     ea;
    logic [7:0]     eb;
    logic [3:0]     esel;
  } ret_t;

  ret_t            pend_q[$];
  ret_t            ent;
  logic [3:0][7:0] pm, vm;
  logic            pc, pd, pz, vc, vd, vz;
  logic            exp_done, exp_ill;
  logic [3:0]      m_op;
  logic [1:0]      m_rd, m_rs;
  logic [7:0]      m_imm, m_a, m_b, m_r;
  int              cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend_q.delete();
      pm = '0; vm = '0;
      pc = 0; pd = 0; pz = 0; vc = 0; vd = 0; vz = 0;
      check("rst_done",    32'(done),       32'(0));
      check("rst_illegal", 32'(illegal),    32'(0));
      check("rst_carry",   32'(carry_flag), 32'(0));
      check("rst_div0",    32'(div0_flag),  32'(0));
      check("rst_alu_a",   32'(alu_a),      32'(0));
      check("rst_alu_b",   32'(alu_b),      32'(0));
      check("rst_alu_sel", 32'(alu_sel),    32'(0));
      check("rst_ready",   32'(in_ready),   32'(1));
      check("rst_dbg",     32'(dbg_data),   32'(0));
`ifdef ALU_ZFLAG_EN
      check("rst_zero",    32'(zero_flag),  32'(0));
`endif
    end else begin
      exp_done = 0;
      exp_ill  = 0;
      if (pend_q.size() > 0 && pend_q[0].wbc == cyc) begin
        check("wb_alu_a",   32'(alu_a),   32'(pend_q[0].ea));
        check("wb_alu_b",   32'(alu_b),   32'(pend_q[0].eb));
        check("wb_alu_sel", 32'(alu_sel), 32'(pend_q[0].esel));
      end
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        vm = pend_q[0].regs;
        vc = pend_q[0].carry;
        vd = pend_q[0].div0;
        vz = pend_q[0].zero;
        exp_done = 1;
        exp_ill  = pend_q[0].ill;
        void'(pend_q.pop_front());
      end
      check("done",     32'(done),       32'(exp_done));
      check("illegal",  32'(illegal),    32'(exp_ill));
      check("in_ready", 32'(in_ready),   32'(pend_q.size() == 0));
      check("carry",    32'(carry_flag), 32'(vc));
      check("div0",     32'(div0_flag),  32'(vd));
      check("dbg_data", 32'(dbg_data),   32'(vm[dbg_addr]));
`ifdef ALU_ZFLAG_EN
      check("zero",     32'(zero_flag),  32'(vz));
`endif
      if (in_valid && in_ready) begin
        m_op  = in_instr[15:12];
        m_rd  = in_instr[11:10];
        m_rs  = in_instr[9:8];
        m_imm = in_instr[7:0];
        m_a   = pm[m_rd];
        m_b   = pm[m_rs];
        ent.ill = 0;
        if (m_op == OP_LOADI) begin
          pm[m_rd] = m_imm;
          pz = (m_imm == 8'd0);
        end else if (m_op == OP_ILL) begin
          ent.ill = 1;
        end else if (m_op == OP_DIV && m_b == 8'd0) begin
          pd = 1;
        end else begin
          m_r = alu_fn(m_op, m_a, m_b);
          pm[m_rd] = m_r;
          pz = (m_r == 8'd0);
          if (m_op == OP_ADD) pc = add_carry(m_a, m_b);
          if (m_op == OP_DIV) pd = 0;
        end
        ent.due   = cyc + 3;
        ent.wbc   = cyc + 2;
        ent.regs  = pm;
        ent.carry = pc;
        ent.div0  = pd;
        ent.zero  = pz;
        ent.ea    = m_a;
        ent.eb    = m_b;
        ent.esel  = (m_op == OP_LOADI) ? 4'd0 : m_op;
        pend_q.push_back(ent);
      end
    end
  end

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    dbg_addr = dbg_addr + 2'd1;
  endtask

  task automatic send(input logic [15:0] ins, input bit hold);
    int n;
    in_valid = 1'b1;
    in_instr = ins;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'(1));
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 10) begin
      tick();
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'(1));
  endtask

  task automatic run(input logic [15:0] ins);
    send(ins, 1'b0);
    wait_done();
  endtask

  task automatic chk_reg(input string name, input logic [1:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  logic [7:0] tbl_exp [14] = '{8'hB8, 8'hB2, 8'h1F, 8'h3C, 8'h6A, 8'h5A, 8'h6B,
                               8'hDA, 8'h01, 8'hB7, 8'hB6, 8'h48, 8'hFE, 8'h49};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    dbg_addr = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: basic add
    run(mk(OP_LOADI, 2'd0, 2'd0, 8'h05));
    run(mk(OP_LOADI, 2'd1, 2'd0, 8'h03));
    run(mk(OP_ADD,   2'd0, 2'd1, 8'h00));
    chk_reg("t1_r0", 2'd0, 8'h08);
    check("t1_carry", 32'(carry_flag), 32'(0));

    // 2: add with carry out, then SUB leaves carry alone
    run(mk(OP_LOADI, 2'd2, 2'd0, 8'hFF));
    run(mk(OP_LOADI, 2'd3, 2'd0, 8'h01));
    run(mk(OP_ADD,   2'd2, 2'd3, 8'h00));
    chk_reg("t2_r2_add", 2'd2, 8'h00);
    check("t2_carry_add", 32'(carry_flag), 32'(1));
    run(mk(OP_SUB,   2'd2, 2'd3, 8'h00));
    chk_reg("t2_r2_sub", 2'd2, 8'hFF);
    check("t2_carry_sub", 32'(carry_flag), 32'(1));

    // 3: divide by zero suppresses writeback, good divide clears flag
    run(mk(OP_LOADI, 2'd1, 2'd0, 8'h10));
    run(mk(OP_LOADI, 2'd2, 2'd0, 8'h00));
    run(mk(OP_DIV,   2'd1, 2'd2, 8'h00));
    chk_reg("t3_r1_div0", 2'd1, 8'h10);
    check("t3_div0_set", 32'(div0_flag), 32'(1));
    run(mk(OP_LOADI, 2'd2, 2'd0, 8'h04));
    run(mk(OP_DIV,   2'd1, 2'd2, 8'h00));
    chk_reg("t3_r1_div", 2'd1, 8'h04);
    check("t3_div0_clr", 32'(div0_flag), 32'(0));

    // 4: back-to-back with in_valid held high
    send(mk(OP_LOADI, 2'd0, 2'd0, 8'h21), 1'b1);
    send(mk(OP_LOADI, 2'd1, 2'd0, 8'h0F), 1'b1);
    send(mk(OP_AND,   2'd0, 2'd1, 8'h00), 1'b1);
    send(mk(OP_XOR,   2'd1, 2'd1, 8'h00), 1'b0);
    wait_done();
    tick();
    chk_reg("t4_r0", 2'd0, 8'h01);
    chk_reg("t4_r1", 2'd1, 8'h00);

    // 5: illegal opcode
    run(mk(OP_ILL, 2'd0, 2'd1, 8'hAA));
    check("t5_illegal", 32'(illegal), 32'(1));
    chk_reg("t5_r0", 2'd0, 8'h01);
    check("t5_carry", 32'(carry_flag), 32'(1));
    check("t5_div0",  32'(div0_flag),  32'(0));

    // Every ALU op with A=0xB5, B=0x03
    run(mk(OP_LOADI, 2'd1, 2'd0, 8'h03));
    for (int k = 0; k < 14; k++) begin
      run(mk(OP_LOADI, 2'd2, 2'd0, 8'hB5));
      run(mk(4'(k), 2'd2, 2'd1, 8'h00));
      chk_reg($sformatf("op_%0d", k), 2'd2, tbl_exp[k]);
    end

    // 6: set both flags, then reset during WB of an ADD
    run(mk(OP_LOADI, 2'd2, 2'd0, 8'hFF));
    run(mk(OP_LOADI, 2'd3, 2'd0, 8'h01));
    run(mk(OP_ADD,   2'd2, 2'd3, 8'h00));
    run(mk(OP_LOADI, 2'd3, 2'd0, 8'h00));
    run(mk(OP_DIV,   2'd0, 2'd3, 8'h00));
    check("t6_carry_pre", 32'(carry_flag), 32'(1));
    check("t6_div0_pre",  32'(div0_flag),  32'(1));
    run(mk(OP_LOADI, 2'd0, 2'd0, 8'h07));
    run(mk(OP_LOADI, 2'd1, 2'd0, 8'h09));
    send(mk(OP_ADD, 2'd0, 2'd1, 8'h00), 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      check("t6_no_done", 32'(done), 32'(0));
    end
    chk_reg("t6_r0", 2'd0, 8'h00);
    chk_reg("t6_r1", 2'd1, 8'h00);
    check("t6_carry", 32'(carry_flag), 32'(0));
    check("t6_div0",  32'(div0_flag),  32'(0));
`ifdef ALU_ZFLAG_EN
    run(mk(OP_LOADI, 2'd1, 2'd0, 8'h05));
    check("t6_zero_clr", 32'(zero_flag), 32'(0));
    run(mk(OP_XOR,   2'd1, 2'd1, 8'h00));
    check("t6_zero_set", 32'(zero_flag), 32'(1));
`endif
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
